// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: sequences the PC and the four pipeline latches (IF_ID, ID_EX,
// EX_MEM, MEM_WB). Owns the IDLE/RUN/DRAIN/HALTED FSM and the saturating
// stall/flush performance counters. Latch controls in RUN are combinational
// from the hazard inputs; every other state decodes them from the state register,
// so an asynchronous reset drops all controls at once.
module pipeline_ctrl #(
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmemREN_mem,
  input  logic             dmemWEN_mem,
  input  logic             halt_mem,
  input  logic             br_taken_mem,
  input  logic             dREN_ex,
  input  logic [4:0]       wsel_ex,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // One spare bit keeps the drain counter at least two bits wide.
  localparam int DCW = $clog2(DRAIN_CYCLES + 1) + 1;
  localparam logic [DCW-1:0]   DRAIN_LAST = DCW'(DRAIN_CYCLES);
  localparam logic [DCW-1:0]   DCNT_ONE   = {{(DCW-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [DCW-1:0]   drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic mem_wait_s;
  logic load_use_s;

  assign mem_wait_s = (dmemREN_mem | dmemWEN_mem) & ~dhit;
  assign load_use_s = dREN_ex & (wsel_ex != 5'd0) &
                      ((wsel_ex == rs_id) | (wsel_ex == rt_id));

  // Next-state, drain/counter updates and latch controls; the first matching RUN rule wins.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = RUN;
      end
      RUN: begin
        if (halt_mem) begin
          // Only the halting instruction's predecessor path keeps retiring.
          memwb_en    = 1'b1;
          state_d     = DRAIN;
          drain_cnt_d = DCNT_ONE;
        end else if (mem_wait_s) begin
          // Whole pipe frozen: all controls stay at their zero defaults.
          pc_en = 1'b0;
        end else if (br_taken_mem) begin
          pc_en       = 1'b1;
          ifid_en     = 1'b1;
          idex_en     = 1'b1;
          exmem_en    = 1'b1;
          memwb_en    = 1'b1;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          if (flush_cnt_q != CNT_MAX) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
          end else begin
            flush_cnt_d = flush_cnt_q;
          end
        end else if (load_use_s) begin
          // IF_ID holds (so a pending fetch simply retries) and a bubble enters EX.
          idex_en    = 1'b1;
          exmem_en   = 1'b1;
          memwb_en   = 1'b1;
          idex_flush = 1'b1;
        end else if (!ihit) begin
          ifid_en    = 1'b1;
          idex_en    = 1'b1;
          exmem_en   = 1'b1;
          memwb_en   = 1'b1;
          ifid_flush = 1'b1;
        end else begin
          pc_en    = 1'b1;
          ifid_en  = 1'b1;
          idex_en  = 1'b1;
          exmem_en = 1'b1;
          memwb_en = 1'b1;
        end
        if (!pc_en && (stall_cnt_q != CNT_MAX)) begin
          stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
          stall_cnt_d = stall_cnt_q;
        end
      end
      DRAIN: begin
        memwb_en = 1'b1;
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = HALTED;
        end else begin
          drain_cnt_d = drain_cnt_q + DCNT_ONE;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, drain count and performance counters; all cleared asynchronously.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      drain_cnt_q <= {DCW{1'b0}};
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign halt      = (state_q == HALTED);
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: table of single-cycle RUN vectors plus
// hand-written sequences for memory freeze, halt/drain, async reset and saturation.
module tb_pipeline_ctrl;

  localparam int CW = 4;

  logic          CLK, nRST;
  logic          ihit, dhit, dmemREN_mem, dmemWEN_mem, halt_mem, br_taken_mem, dREN_ex;
  logic [4:0]    wsel_ex, rs_id, rt_id;
  logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic          ifid_flush, idex_flush, exmem_flush, memwb_flush, halt;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_tests, n_fail;
  logic [CW-1:0] m_stall, m_flush;

  pipeline_ctrl #(.CNT_W(CW), .DRAIN_CYCLES(2)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .dmemREN_mem(dmemREN_mem), .dmemWEN_mem(dmemWEN_mem), .halt_mem(halt_mem),
    .br_taken_mem(br_taken_mem), .dREN_ex(dREN_ex), .wsel_ex(wsel_ex),
    .rs_id(rs_id), .rt_id(rt_id), .pc_en(pc_en), .ifid_en(ifid_en),
    .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .memwb_flush(memwb_flush), .halt(halt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Expected control word: {pc, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, exmem_fl, memwb_fl}
  localparam logic [8:0] E_ALL0  = 9'b0_0000_0000;
  localparam logic [8:0] E_RUN   = 9'b1_1111_0000;
  localparam logic [8:0] E_LDUSE = 9'b0_0111_0100;
  localparam logic [8:0] E_IMISS = 9'b0_1111_1000;
  localparam logic [8:0] E_BR    = 9'b1_1111_1110;
  localparam logic [8:0] E_MEMWB = 9'b0_0001_0000;

  typedef struct {
    string      name;
    logic       ih, dh, ren, wen, br, dren;
    logic [4:0] wsel, rs, rt;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[13];

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    logic [CW-1:0] mx;
    mx = {CW{1'b1}};
    return (v == mx) ? v : v + {{(CW-1){1'b0}}, 1'b1};
  endfunction

  task automatic set_in(input logic ih, dh, ren, wen, hm, br, dren,
                        input logic [4:0] wsel, rs, rt);
    ihit = ih; dhit = dh; dmemREN_mem = ren; dmemWEN_mem = wen; halt_mem = hm;
    br_taken_mem = br; dREN_ex = dren; wsel_ex = wsel; rs_id = rs; rt_id = rt;
  endtask

  task automatic check_out(input string name, input logic [8:0] exp, input logic exp_halt);
    logic [8:0] got;
    got = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush};
    n_tests++;
    if (got !== exp || halt !== exp_halt) begin
      n_fail++;
      $display("FAIL %s: ctrl=%b halt=%b, expected ctrl=%b halt=%b",
               name, got, halt, exp, exp_halt);
    end
  endtask

  task automatic check_cnt(input string name);
    n_tests++;
    if (stall_cnt !== m_stall || flush_cnt !== m_flush) begin
      n_fail++;
      $display("FAIL %s: stall_cnt=%0d flush_cnt=%0d, expected %0d/%0d",
               name, stall_cnt, flush_cnt, m_stall, m_flush);
    end
  endtask

  // Inputs already applied at posedge+1; check controls mid-cycle, clock, update model, check counters.
  task automatic run_cycle(input string name, input logic [8:0] exp,
                           input logic exp_halt, input logic in_run);
    #3;
    check_out(name, exp, exp_halt);
    @(posedge CLK); #1;
    if (in_run && !exp[8]) m_stall = sat_inc(m_stall);
    if (in_run && exp[1])  m_flush = sat_inc(m_flush);
    check_cnt({name, "_cnt"});
  endtask

  // Async reset pulse at mid-cycle, then release and walk through the IDLE bubble into RUN.
  task automatic do_reset(input string name);
    #2;
    nRST = 1'b0;
    #1;
    m_stall = '0; m_flush = '0;
    check_out({name, "_async"}, E_ALL0, 1'b0);
    check_cnt({name, "_async_cnt"});
    @(posedge CLK); #1;
    nRST = 1'b1;
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    run_cycle({name, "_idle"}, E_ALL0, 1'b0, 1'b0);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; m_stall = '0; m_flush = '0;
    tbl[0]  = '{"default",     1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 5'd0, 5'd0, 5'd0, E_RUN};
    tbl[1]  = '{"lduse_rs",    1'b1,1'b1,1'b0,1'b0,1'b0,1'b1, 5'd5, 5'd5, 5'd1, E_LDUSE};
    tbl[2]  = '{"lduse_rt",    1'b1,1'b1,1'b0,1'b0,1'b0,1'b1, 5'd7, 5'd2, 5'd7, E_LDUSE};
    tbl[3]  = '{"lduse_r0",    1'b1,1'b1,1'b0,1'b0,1'b0,1'b1, 5'd0, 5'd0, 5'd0, E_RUN};
    tbl[4]  = '{"noload_dep",  1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 5'd5, 5'd5, 5'd5, E_RUN};
    tbl[5]  = '{"imiss",       1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 5'd0, 5'd0, 5'd0, E_IMISS};
    tbl[6]  = '{"lduse_imiss", 1'b0,1'b1,1'b0,1'b0,1'b0,1'b1, 5'd9, 5'd9, 5'd3, E_LDUSE};
    tbl[7]  = '{"branch",      1'b1,1'b1,1'b0,1'b0,1'b1,1'b0, 5'd0, 5'd0, 5'd0, E_BR};
    tbl[8]  = '{"br_lduse",    1'b0,1'b1,1'b0,1'b0,1'b1,1'b1, 5'd4, 5'd4, 5'd4, E_BR};
    tbl[9]  = '{"store_wait",  1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 5'd0, 5'd0, 5'd0, E_ALL0};
    tbl[10] = '{"load_hit",    1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, 5'd0, 5'd0, 5'd0, E_RUN};
    tbl[11] = '{"wait_br",     1'b1,1'b0,1'b1,1'b0,1'b1,1'b1, 5'd6, 5'd6, 5'd0, E_ALL0};
    tbl[12] = '{"nomem_dmiss", 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 5'd0, 5'd0, 5'd0, E_RUN};

    // Power-on reset and T1 start bubble.
    nRST = 1'b0;
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    #1;
    check_out("reset", E_ALL0, 1'b0);
    check_cnt("reset_cnt");
    @(posedge CLK); #1;
    nRST = 1'b1;
    run_cycle("t1_idle", E_ALL0, 1'b0, 1'b0);
    run_cycle("t1_run", E_RUN, 1'b0, 1'b1);

    // Single-cycle RUN rule table (T2, T3 and priority cases).
    for (int i = 0; i < 13; i++) begin
      set_in(tbl[i].ih, tbl[i].dh, tbl[i].ren, tbl[i].wen, 1'b0, tbl[i].br,
             tbl[i].dren, tbl[i].wsel, tbl[i].rs, tbl[i].rt);
      run_cycle(tbl[i].name, tbl[i].exp, 1'b0, 1'b1);
    end

    // T4: data miss with pending branch freezes 3 cycles, then the branch flushes.
    do_reset("t4_rst");
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
      run_cycle("t4_freeze", E_ALL0, 1'b0, 1'b1);
    end
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    run_cycle("t4_flush", E_BR, 1'b0, 1'b1);
    n_tests++;
    if (stall_cnt !== 4'd3 || flush_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL t4_totals: stall_cnt=%0d flush_cnt=%0d, expected 3/1", stall_cnt, flush_cnt);
    end

    // T5: halt reaches MEM, two drain cycles, then sticky halt despite input activity.
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    run_cycle("t5_halt_run", E_MEMWB, 1'b0, 1'b1);
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 5'd3, 5'd3);
    run_cycle("t5_drain1", E_MEMWB, 1'b0, 1'b0);
    run_cycle("t5_drain2", E_MEMWB, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      set_in(i[0], 1'b1, 1'b0, 1'b0, i[1], ~i[0], 1'b0, 5'd0, 5'd0, 5'd0);
      run_cycle("t5_halted", E_ALL0, 1'b1, 1'b0);
    end

    // T6a: reset out of HALTED, then reset again in the middle of DRAIN.
    do_reset("t6_rst_halted");
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    run_cycle("t6_halt_run", E_MEMWB, 1'b0, 1'b1);
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    #1;
    check_out("t6_in_drain", E_MEMWB, 1'b0);
    do_reset("t6_rst_drain");
    run_cycle("t6_rerun", E_RUN, 1'b0, 1'b1);

    // T6b: accumulate 7 stalls, reset, then drive both counters into saturation.
    for (int i = 0; i < 7; i++) begin
      set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      run_cycle("t6_stall", E_IMISS, 1'b0, 1'b1);
    end
    n_tests++;
    if (stall_cnt !== 4'd7) begin
      n_fail++;
      $display("FAIL t6_stall7: stall_cnt=%0d, expected 7", stall_cnt);
    end
    do_reset("t6_rst_cnt7");
    for (int i = 0; i < 20; i++) begin
      set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      run_cycle("sat_stall", E_IMISS, 1'b0, 1'b1);
    end
    for (int i = 0; i < 20; i++) begin
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
      run_cycle("sat_flush", E_BR, 1'b0, 1'b1);
    end
    n_tests++;
    if (stall_cnt !== 4'hF || flush_cnt !== 4'hF) begin
      n_fail++;
      $display("FAIL sat_final: stall_cnt=%0d flush_cnt=%0d, expected 15/15", stall_cnt, flush_cnt);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
